// File: rtl/booth_multiplier_pkg.sv
// booth_pkg: shared definitions for the sequential radix-2 Booth multiplier.
//   state_t          FSM state encoding (IDLE / RUN / DONE)
//   BOOTH_N_DEFAULT  default operand width
package booth_pkg;

  localparam int BOOTH_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : booth_pkg

// File: rtl/booth_multiplier_step.sv
// booth_step: one combinational radix-2 Booth iteration.
// Adds or subtracts M into A according to {Q[0], Q_1}, then arithmetic-shifts
// the concatenation {A, Q, Q_1} right by one bit.
// Ports:
//   i_a   [N:0]   partial product accumulator (one guard bit)
//   i_q   [N-1:0] multiplier shift register
//   i_q1          previously shifted-out multiplier bit
//   i_m   [N:0]   sign-extended multiplicand
//   o_a, o_q, o_q1  updated register values after add/sub and shift
module booth_step #(
  parameter int N = 8
) (
  input  logic [N:0]   i_a,
  input  logic [N-1:0] i_q,
  input  logic         i_q1,
  input  logic [N:0]   i_m,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q,
  output logic         o_q1
);

  logic [N:0] w_sum;

  always_comb begin
    w_sum = i_a;
    unique case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  // Arithmetic shift: replicate the accumulator MSB into the vacated top bit.
  assign {o_a, o_q, o_q1} = {w_sum[N], w_sum, i_q};

endmodule : booth_step

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-2 Booth multiplier.
// Multiplies two N-bit two's-complement operands over N iteration cycles and
// holds the 2N-bit product on a registered output.
// Ports (positional order is fixed for existing instances):
//   start       level-sensitive request, sampled only in IDLE
//   clk_100MHz  system clock, rising edge
//   data_inM    N-bit signed multiplicand
//   data_inQ    N-bit signed multiplier
//   ans         2N-bit signed product, registered
//   rst         asynchronous active-high reset
//   done        one-cycle pulse with each ans update (only with BOOTH_DONE_EN)
// Optional feature macro: BOOTH_DONE_EN adds the done output.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N_DEFAULT
) (
  input  logic           start,
  input  logic           clk_100MHz,
  input  logic [N-1:0]   data_inM,
  input  logic [N-1:0]   data_inQ,
  output logic [2*N-1:0] ans,
  input  logic           rst
`ifdef BOOTH_DONE_EN
  ,
  output logic           done
`endif
);

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [N:0]     r_a;
  logic [N:0]     r_m;
  logic [N-1:0]   r_q;
  logic           r_q1;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_ans;

  logic [N:0]     w_a_next;
  logic [N-1:0]   w_q_next;
  logic           w_q1_next;

  booth_step #(.N(N)) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_next),
    .o_q  (w_q_next),
    .o_q1 (w_q1_next)
  );

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // The last iteration is the one that takes the counter from 1 to 0.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (r_count == CW'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      r_ans   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= {data_inM[N-1], data_inM};
            r_a     <= '0;
            r_q     <= data_inQ;
            r_q1    <= 1'b0;
            r_count <= CW'(N);
          end
        end
        RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_q1    <= w_q1_next;
          r_count <= r_count - CW'(1);
        end
        DONE: begin
          // Guard bit of A is dropped: the exact product always fits 2N bits.
          r_ans <= {r_a[N-1:0], r_q};
        end
        default: ;
      endcase
    end
  end

  assign ans = r_ans;

`ifdef BOOTH_DONE_EN
  logic r_done;

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == DONE);
  end

  assign done = r_done;
`endif

endmodule : booth_multiplier

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: self-checking bench for booth_multiplier (N = 8).
// Expected products are pushed to a scoreboard queue when an operation is
// launched and popped when the product is due on ans.
module tb_booth_multiplier;

  localparam int N = 8;

  logic           clk_100MHz;
  logic           rst;
  logic           start;
  logic [N-1:0]   data_inM;
  logic [N-1:0]   data_inQ;
  logic [2*N-1:0] ans;
`ifdef BOOTH_DONE_EN
  logic           done;
`endif

  int unsigned n_checks;
  int unsigned n_errors;
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] prev_ans;

  booth_multiplier #(.N(N)) dut (
    .start      (start),
    .clk_100MHz (clk_100MHz),
    .data_inM   (data_inM),
    .data_inQ   (data_inQ),
    .ans        (ans),
    .rst        (rst)
`ifdef BOOTH_DONE_EN
    ,
    .done       (done)
`endif
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] m, input logic [N-1:0] q);
    logic signed [2*N-1:0] sm;
    logic signed [2*N-1:0] sq;
    logic signed [2*N-1:0] p;
    sm = {{N{m[N-1]}}, m};
    sq = {{N{q[N-1]}}, q};
    p  = sm * sq;
    return p;
  endfunction

  // Launch one operation. hold keeps start high afterwards; perturb_at changes
  // the operand inputs after that iteration edge; rst_at asserts reset after
  // that iteration edge and abandons the operation.
  task automatic do_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                       input bit hold, input int perturb_at, input int rst_at);
    logic [2*N-1:0] e;
    @(negedge clk_100MHz);
    data_inM = m;
    data_inQ = q;
    start    = 1'b1;
    @(posedge clk_100MHz);
    exp_q.push_back(model(m, q));
    #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk_100MHz);
      #1;
      if (k == perturb_at) begin
        data_inM = {1'b0, {(N-1){1'b1}}};
        data_inQ = {1'b0, {(N-1){1'b1}}};
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_ans"}, 32'(ans), 32'h0);
`ifdef BOOTH_DONE_EN
        check_eq({tag, "_rst_done"}, 32'(done), 32'h0);
`endif
        void'(exp_q.pop_front());
        prev_ans = '0;
        @(negedge clk_100MHz);
        rst = 1'b0;
        return;
      end
      if (k == N) begin
        check_eq({tag, "_hold"}, 32'(ans), 32'(prev_ans));
`ifdef BOOTH_DONE_EN
        check_eq({tag, "_done_early"}, 32'(done), 32'h0);
`endif
      end
      if (k == N + 1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s_sb: scoreboard empty, got 0x%0h", tag, ans);
        end else begin
          e = exp_q.pop_front();
          check_eq({tag, "_ans"}, 32'(ans), 32'(e));
          prev_ans = e;
        end
`ifdef BOOTH_DONE_EN
        check_eq({tag, "_done"}, 32'(done), 32'h1);
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_ans = '0;
    rst      = 1'b1;
    start    = 1'b0;
    data_inM = '0;
    data_inQ = '0;
    #23;
    check_eq("reset_ans", 32'(ans), 32'h0);
`ifdef BOOTH_DONE_EN
    check_eq("reset_done", 32'(done), 32'h0);
`endif
    @(negedge clk_100MHz);
    rst = 1'b0;

    // start held high: back-to-back identical runs, N+2 cycles apart
    do_op("m31q39_a", 8'h1F, 8'h27, 1'b1, 0, 0);
    check_eq("m31q39_const", 32'(prev_ans), 32'h04B9);
    do_op("m31q39_b", 8'h1F, 8'h27, 1'b1, 0, 0);
    do_op("m31q39_c", 8'h1F, 8'h27, 1'b0, 0, 0);

    do_op("neg128sq", 8'h80, 8'h80, 1'b0, 0, 0);
    check_eq("neg128sq_const", 32'(ans), 32'h4000);
    do_op("neg128x127", 8'h80, 8'h7F, 1'b0, 0, 0);
    check_eq("neg128x127_const", 32'(ans), 32'hC080);
    do_op("neg1x1", 8'hFF, 8'h01, 1'b0, 0, 0);
    check_eq("neg1x1_const", 32'(ans), 32'hFFFF);
    do_op("zero", 8'h00, 8'h5A, 1'b0, 0, 0);
    check_eq("zero_const", 32'(ans), 32'h0000);

    // operand change during RUN must be ignored
    do_op("midrun", 8'h03, 8'h05, 1'b0, 3, 0);
    check_eq("midrun_const", 32'(ans), 32'h000F);

    // reset at E4, then restart
    do_op("rst_e4", 8'h1F, 8'h27, 1'b0, 0, 4);
    do_op("after_rst", 8'hF3, 8'h6B, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      do_op("rand", N'($urandom), N'($urandom), 1'b0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_booth_multiplier
